// File: rtl/muldiv_unit_rv32m_pkg.sv
// Shared constants, op/state encodings and operand-signedness helpers for the RV32M unit.
package rv32m_pkg;

  localparam int XLEN = 32;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_rv32m_sign_fix.sv
// Two-lane conditional negate: extracts sign/magnitude on the way in, applies sign on the way out.
module rv32m_sign_fix #(
  parameter int A_W = 32,
  parameter int B_W = 32
) (
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  input  logic           i_a_signed,
  input  logic           i_b_signed,
  input  logic           i_a_neg,
  input  logic           i_b_neg,
  output logic [A_W-1:0] o_a,
  output logic [B_W-1:0] o_b,
  output logic           o_sign_a,
  output logic           o_sign_b
);

  assign o_sign_a = i_a_signed & i_a[A_W-1];
  assign o_sign_b = i_b_signed & i_b[B_W-1];

  // A negative signed input is turned into its magnitude; i_*_neg requests a negation on top.
  assign o_a = (o_sign_a ^ i_a_neg) ? -i_a : i_a;
  assign o_b = (o_sign_b ^ i_b_neg) ? -i_b : i_b;

endmodule

// File: rtl/muldiv_unit_rv32m.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add / restoring divide on magnitudes, sign fixed at the end.
module muldiv_unit_rv32m
  import rv32m_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_m,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [2:0]            r_f3;
  logic                  r_sign_a;
  logic                  r_sign_b;
  logic                  r_dz;
  logic [XLEN-1:0]       r_opnd;
  logic [2*XLEN-1:0]     r_acc;
  logic                  r_done;
  logic [XLEN-1:0]       r_result;

  logic [XLEN-1:0]       w_mag_a;
  logic [XLEN-1:0]       w_mag_b;
  logic                  w_sign_a;
  logic                  w_sign_b;
  logic                  w_accept;
  logic [XLEN:0]         w_mul_sum;
  logic [2*XLEN-1:0]     w_mul_next;
  logic                  w_div_ge;
  logic [XLEN-1:0]       w_div_rem;
  logic [2*XLEN-1:0]     w_div_next;
  logic [2*XLEN-1:0]     w_fix_a_in;
  logic [2*XLEN-1:0]     w_fix_a;
  logic [XLEN-1:0]       w_fix_b;
  logic                  w_unused_sign_a;
  logic                  w_unused_sign_b;
  logic [XLEN-1:0]       w_result;

  rv32m_sign_fix #(.A_W(XLEN), .B_W(XLEN)) u_sign_in (
    .i_a        (op_a),
    .i_b        (op_b),
    .i_a_signed (a_signed(funct3)),
    .i_b_signed (b_signed(funct3)),
    .i_a_neg    (1'b0),
    .i_b_neg    (1'b0),
    .o_a        (w_mag_a),
    .o_b        (w_mag_b),
    .o_sign_a   (w_sign_a),
    .o_sign_b   (w_sign_b)
  );

  assign w_accept = (r_state == ST_IDLE) && start && is_m && !flush;

  // Multiply: r_acc = {partial high, remaining multiplier bits}; divide: r_acc = {remainder, dividend/quotient}.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_div_ge   = r_acc[2*XLEN-1:XLEN-1] >= {1'b0, r_opnd};
  assign w_div_rem  = r_acc[2*XLEN-2:XLEN-1] - r_opnd;
  assign w_div_next = w_div_ge ? {w_div_rem, r_acc[XLEN-2:0], 1'b1} : {r_acc[2*XLEN-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_CALC;
            r_cnt   <= '0;
          end
        end
        ST_CALC: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == {CNT_W{1'b1}}) r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          if (!flush) begin
            r_done   <= 1'b1;
            r_result <= w_result;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_f3     <= funct3;
      r_sign_a <= w_sign_a;
      r_sign_b <= w_sign_b;
      r_dz     <= is_div(funct3) && (op_b == '0);
      r_opnd   <= is_div(funct3) ? w_mag_b : w_mag_a;
      r_acc    <= {{XLEN{1'b0}}, (is_div(funct3) ? w_mag_a : w_mag_b)};
    end else if (r_state == ST_CALC) begin
      r_acc <= is_div(r_f3) ? w_div_next : w_mul_next;
    end
  end

  assign w_fix_a_in = is_div(r_f3) ? {{XLEN{1'b0}}, r_acc[XLEN-1:0]} : r_acc;

  rv32m_sign_fix #(.A_W(2*XLEN), .B_W(XLEN)) u_sign_out (
    .i_a        (w_fix_a_in),
    .i_b        (r_acc[2*XLEN-1:XLEN]),
    .i_a_signed (1'b0),
    .i_b_signed (1'b0),
    .i_a_neg    (r_sign_a ^ r_sign_b),
    .i_b_neg    (r_sign_a),
    .o_a        (w_fix_a),
    .o_b        (w_fix_b),
    .o_sign_a   (w_unused_sign_a),
    .o_sign_b   (w_unused_sign_b)
  );

  // With a zero divisor the remainder magnitude is |op_a|, so restoring the dividend sign yields op_a itself.
  always_comb begin
    w_result = w_fix_a[XLEN-1:0];
    case (r_f3)
      F3_MUL:                       w_result = w_fix_a[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_result = w_fix_a[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_result = r_dz ? '1 : w_fix_a[XLEN-1:0];
      F3_REM, F3_REMU:              w_result = w_fix_b;
      default:                      w_result = w_fix_a[XLEN-1:0];
    endcase
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit_rv32m.sv
// Scoreboard bench for muldiv_unit_rv32m: expected results queued at issue, checked when done pulses.
module tb_muldiv_unit_rv32m;

  localparam int K_NORM  = 0;
  localparam int K_FLUSH = 1;
  localparam int K_BUSY  = 2;
  localparam int K_RST   = 3;
  localparam int K_NOM   = 4;
  localparam int K_FLST  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_m = 1'b1;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  logic [31:0] last_res = 32'd0;
  logic [31:0] mon_e;
  int          mon_c;

  muldiv_unit_rv32m #(.XLEN(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_m   (is_m),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference semantics straight from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    logic [63:0] p;
    logic        ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = longint'(sa) * longint'(sb);           return p[31:0];  end
      3'd1: begin p = longint'(sa) * longint'(sb);           return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'd0, b});   return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b};               return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at a negedge while the unit is idle; returns at the negedge of cycle 34.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int kind);
    int          n0;
    int          busy_end;
    logic [31:0] e;
    e        = ref_m(f3, a, b);
    n0       = cyc;
    start    = 1'b1;
    is_m     = (kind != K_NOM);
    flush    = (kind == K_FLST);
    funct3   = f3;
    op_a     = a;
    op_b     = b;
    case (kind)
      K_NORM, K_BUSY: busy_end = 33;
      K_FLUSH:        busy_end = 10;
      K_RST:          busy_end = 20;
      default:        busy_end = 0;
    endcase
    if (kind == K_NORM || kind == K_BUSY) begin
      exp_q.push_back(e);
      cyc_q.push_back(n0);
    end
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      start  = 1'b0;
      is_m   = 1'b1;
      flush  = 1'b0;
      rst    = 1'b0;
      op_a   = $urandom;
      op_b   = $urandom;
      funct3 = 3'($urandom_range(0, 7));
      chk("busy", {31'd0, busy}, (k <= busy_end) ? 32'd1 : 32'd0);
      if (kind == K_FLUSH && k == 10) flush = 1'b1;
      if (kind == K_BUSY && k == 5) start = 1'b1;
      if (kind == K_RST && k == 20) rst = 1'b1;
      if (kind == K_RST && k == 21) begin
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
      end
      if ((kind == K_FLUSH || kind == K_NOM || kind == K_FLST) && k == 34)
        chk("held_result", result, last_res);
    end
    if (kind == K_NORM || kind == K_BUSY) last_res = e;
    if (kind == K_RST) last_res = 32'd0;
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: result %h with no outstanding op (cycle %0d)", result, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        chk("result", result, mon_e);
        chk("latency", 32'(cyc - mon_c), 32'd34);
      end
    end
  end

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  d_f3[14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                            3'd4, 3'd7, 3'd5, 3'd4, 3'd6, 3'd6};
  logic [31:0] d_a[14]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                            32'd5, 32'd5, 32'd0, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
  logic [31:0] d_b[14]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'd2, 32'd2, 32'd7, 32'd7,
                            32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_op(d_f3[i], d_a[i], d_b[i], K_NORM);

    run_op(3'd0, 32'd123, 32'd456, K_FLUSH);
    run_op(3'd0, 32'd9, 32'd9, K_NOM);
    run_op(3'd5, 32'd1000, 32'd10, K_BUSY);
    run_op(3'd1, 32'd77, 32'd88, K_FLST);
    run_op(3'd3, 32'd5, 32'd6, K_NORM);
    run_op(3'd0, 32'd11, 32'd12, K_RST);
    run_op(3'd7, 32'd50, 32'd8, K_NORM);

    for (int i = 0; i < 150; i++) run_op(3'($urandom_range(0, 7)), pick_opnd(), pick_opnd(), K_NORM);

    repeat (3) @(negedge clk);
    chk("pending_ops", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
